// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Parametrised raster timing generator. Produces h/v counters,
//                sync, blanking, active-relative coordinates, line/frame
//                strobes and an early-fetch window, all as registered outputs
//                decoded from the next counter values.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int CW        = 11,
  parameter int H_BP      = 48,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int V_BP      = 33,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int H_WIN_OFF = 64,
  parameter int H_WIN     = 512,
  parameter int V_WIN_OFF = 112,
  parameter int V_WIN     = 256,
  parameter int PREFETCH  = 2
) (
  input  logic          px_clk,
  input  logic          clr,
  input  logic          en,
  input  logic          mode,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          prefetch
);

  localparam int c_H_TOTAL = H_BP + H_ACTIVE + H_FP + H_SYNC;
  localparam int c_V_TOTAL = V_BP + V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CW-1:0] c_H_LAST   = CW'(c_H_TOTAL - 1);
  localparam logic [CW-1:0] c_V_LAST   = CW'(c_V_TOTAL - 1);
  localparam logic [CW-1:0] c_HSYNC_ST = CW'(H_BP + H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_VSYNC_ST = CW'(V_BP + V_ACTIVE + V_FP);

  // Window edges for the two geometries (start inclusive, end exclusive)
  localparam logic [CW-1:0] c_HS_FULL = CW'(H_BP);
  localparam logic [CW-1:0] c_HE_FULL = CW'(H_BP + H_ACTIVE);
  localparam logic [CW-1:0] c_VS_FULL = CW'(V_BP);
  localparam logic [CW-1:0] c_VE_FULL = CW'(V_BP + V_ACTIVE);
  localparam logic [CW-1:0] c_HS_WIN  = CW'(H_BP + H_WIN_OFF);
  localparam logic [CW-1:0] c_HE_WIN  = CW'(H_BP + H_WIN_OFF + H_WIN);
  localparam logic [CW-1:0] c_VS_WIN  = CW'(V_BP + V_WIN_OFF);
  localparam logic [CW-1:0] c_VE_WIN  = CW'(V_BP + V_WIN_OFF + V_WIN);
  localparam logic [CW-1:0] c_PF      = CW'(PREFETCH);

  logic          r_mode;
  logic          w_h_wrap;
  logic          w_frame_end;
  logic          w_mode_nx;
  logic [CW-1:0] w_hc_nx;
  logic [CW-1:0] w_vc_nx;
  logic [CW-1:0] w_hs;
  logic [CW-1:0] w_he;
  logic [CW-1:0] w_vs;
  logic [CW-1:0] w_ve;
  logic          w_hblank;
  logic          w_vblank;
  logic          w_active;
  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;
  logic          w_prefetch;
  logic          w_hsync;
  logic          w_vsync;

  // Next counter values and decode of every flag from them, so the registered
  // flags line up with the registered counters with no skew.
  always_comb begin
    w_h_wrap    = (hc == c_H_LAST);
    w_frame_end = w_h_wrap && (vc == c_V_LAST);
    w_hc_nx     = w_h_wrap ? '0 : hc + CW'(1);
    w_vc_nx     = vc;
    if (w_h_wrap) begin
      w_vc_nx = (vc == c_V_LAST) ? '0 : vc + CW'(1);
    end
    // The geometry sample lands on the last cycle of the frame, so the next
    // frame's first pixel is already decoded with the new mode.
    w_mode_nx = w_frame_end ? mode : r_mode;

    w_hs = w_mode_nx ? c_HS_WIN : c_HS_FULL;
    w_he = w_mode_nx ? c_HE_WIN : c_HE_FULL;
    w_vs = w_mode_nx ? c_VS_WIN : c_VS_FULL;
    w_ve = w_mode_nx ? c_VE_WIN : c_VE_FULL;

    w_hblank   = (w_hc_nx < w_hs) || (w_hc_nx >= w_he);
    w_vblank   = (w_vc_nx < w_vs) || (w_vc_nx >= w_ve);
    w_active   = !w_hblank && !w_vblank;
    w_x        = w_active  ? (w_hc_nx - w_hs) : '0;
    w_y        = !w_vblank ? (w_vc_nx - w_vs) : '0;
    w_prefetch = !w_vblank && (w_hc_nx >= (w_hs - c_PF)) &&
                 (w_hc_nx < (w_he - c_PF));
    // Sync pulses sit at the end of line/frame independent of the window
    w_hsync    = (w_hc_nx >= c_HSYNC_ST) ? HS_POL : ~HS_POL;
    w_vsync    = (w_vc_nx >= c_VSYNC_ST) ? VS_POL : ~VS_POL;
  end

  // Counter, mode and output registers; a stalled enable freezes all of them
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      hc          <= '0;
      vc          <= '0;
      r_mode      <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      prefetch    <= 1'b0;
    end else if (en) begin
      hc          <= w_hc_nx;
      vc          <= w_vc_nx;
      r_mode      <= w_mode_nx;
      hsync       <= w_hsync;
      vsync       <= w_vsync;
      hblank      <= w_hblank;
      vblank      <= w_vblank;
      active      <= w_active;
      x           <= w_x;
      y           <= w_y;
      line_start  <= (w_hc_nx == '0);
      frame_start <= (w_hc_nx == '0) && (w_vc_nx == '0);
      prefetch    <= w_prefetch;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen using a reduced
//                raster (25 x 14, full window 16x8 at 4,3; windowed 8x4 at
//                8,5; hsync hc 22..24, vsync vc 12..13, prefetch lead 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  localparam int CW = 8;
  localparam int HT = 25;
  localparam int VT = 14;

  logic          px_clk, clr, en, mode;
  logic [CW-1:0] hc, vc, x, y, hc2, vc2, x2, y2;
  logic          hsync, vsync, hblank, vblank, active, line_start, frame_start, prefetch;
  logic          hsync2, vsync2, hblank2, vblank2, active2, ls2, fs2, pf2;

  video_timing_gen #(
    .CW(CW), .H_BP(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3),
    .V_BP(3), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .H_WIN_OFF(4), .H_WIN(8), .V_WIN_OFF(2), .V_WIN(4), .PREFETCH(2)
  ) dut (
    .px_clk(px_clk), .clr(clr), .en(en), .mode(mode),
    .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .active(active),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .prefetch(prefetch)
  );

  video_timing_gen #(
    .CW(CW), .H_BP(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3),
    .V_BP(3), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .H_WIN_OFF(4), .H_WIN(8), .V_WIN_OFF(2), .V_WIN(4), .PREFETCH(2)
  ) dut_pos (
    .px_clk(px_clk), .clr(clr), .en(en), .mode(mode),
    .hc(hc2), .vc(vc2), .hsync(hsync2), .vsync(vsync2),
    .hblank(hblank2), .vblank(vblank2), .active(active2),
    .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2),
    .prefetch(pf2)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  int checks = 0;
  int errors = 0;

  // Reference state: counters and latched mode
  int m_hc = 0;
  int m_vc = 0;
  bit m_mode = 1'b0;

  // flags order: hsync vsync hblank vblank active line_start frame_start prefetch
  typedef struct {
    int         n;
    bit         en;
    bit         md;
    int         h;
    int         v;
    logic [7:0] fl;
    int         x;
    int         y;
  } vec_t;

  vec_t vt[31];

  function automatic logic [39:0] pack(int h, int v, logic [7:0] fl, int px, int py);
    return {8'(h), 8'(v), fl, 8'(px), 8'(py)};
  endfunction

  function automatic logic [39:0] got_vec();
    return {hc, vc, hsync, vsync, hblank, vblank, active, line_start, frame_start, prefetch, x, y};
  endfunction

  // Expected outputs for a counter position and geometry, straight from the decode rules
  function automatic logic [39:0] model_vec(int h, int v, bit md);
    int hs, he, vs, ve, px, py;
    bit hb, vb, act, pf;
    hs  = md ? 8  : 4;
    he  = md ? 16 : 20;
    vs  = md ? 5  : 3;
    ve  = md ? 9  : 11;
    hb  = (h < hs) || (h >= he);
    vb  = (v < vs) || (v >= ve);
    act = !hb && !vb;
    px  = act ? h - hs : 0;
    py  = !vb ? v - vs : 0;
    pf  = !vb && (h >= hs - 2) && (h < he - 2);
    return pack(h, v, {!(h >= 22), !(v >= 12), hb, vb, act, h == 0, (h == 0) && (v == 0), pf}, px, py);
  endfunction

  task automatic cmp(string nm, logic [39:0] got, logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got hc=%0d vc=%0d fl=%b x=%0d y=%0d exp hc=%0d vc=%0d fl=%b x=%0d y=%0d",
               nm, got[39:32], got[31:24], got[23:16], got[15:8], got[7:0],
               exp[39:32], exp[31:24], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic check_model(string nm);
    cmp(nm, got_vec(), model_vec(m_hc, m_vc, m_mode));
    checks++;
    if ({hsync2, vsync2} !== {(m_hc >= 22), (m_vc >= 12)}) begin
      errors++;
      $display("FAIL %s_pol got hs=%b vs=%b exp hs=%b vs=%b (hc=%0d vc=%0d)",
               nm, hsync2, vsync2, (m_hc >= 22), (m_vc >= 12), m_hc, m_vc);
    end
  endtask

  // One clock edge; the reference advances with the inputs seen at that edge
  task automatic tick();
    @(posedge px_clk);
    if (en) begin
      if (m_hc == HT - 1 && m_vc == VT - 1) m_mode = mode;
      if (m_hc == HT - 1) begin
        m_hc = 0;
        m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
      end else begin
        m_hc = m_hc + 1;
      end
    end
    #1;
  endtask

  initial begin
    int since;
    bit seen;

    //          n    en md  hc  vc  flags         x   y
    vt[0]  = '{0,   1, 0,  0,  0, 8'b11110110,  0, 0};
    vt[1]  = '{1,   1, 0,  1,  0, 8'b11110000,  0, 0};
    vt[2]  = '{78,  1, 0,  4,  3, 8'b11001001,  0, 0};
    vt[3]  = '{190, 1, 0, 19, 10, 8'b11001000, 15, 7};
    vt[4]  = '{1,   1, 0, 20, 10, 8'b11100000,  0, 7};
    vt[5]  = '{2,   1, 0, 22, 10, 8'b01100000,  0, 7};
    vt[6]  = '{3,   1, 0,  0, 11, 8'b11110100,  0, 0};
    vt[7]  = '{25,  1, 0,  0, 12, 8'b10110100,  0, 0};
    vt[8]  = '{49,  1, 0, 24, 13, 8'b00110000,  0, 0};
    vt[9]  = '{1,   1, 0,  0,  0, 8'b11110110,  0, 0};
    vt[10] = '{76,  1, 0,  1,  3, 8'b11100000,  0, 0};
    vt[11] = '{1,   1, 0,  2,  3, 8'b11100001,  0, 0};
    vt[12] = '{15,  1, 0, 17,  3, 8'b11001001, 13, 0};
    vt[13] = '{1,   1, 0, 18,  3, 8'b11001000, 14, 0};
    vt[14] = '{36,  1, 1,  4,  5, 8'b11001001,  0, 2};
    vt[15] = '{220, 1, 1, 24, 13, 8'b00110000,  0, 0};
    vt[16] = '{1,   1, 1,  0,  0, 8'b11110110,  0, 0};
    vt[17] = '{131, 1, 1,  6,  5, 8'b11100001,  0, 0};
    vt[18] = '{2,   1, 1,  8,  5, 8'b11001001,  0, 0};
    vt[19] = '{82,  1, 1, 15,  8, 8'b11001000,  7, 3};
    vt[20] = '{1,   1, 1, 16,  8, 8'b11100000,  0, 3};
    vt[21] = '{9,   1, 1,  0,  9, 8'b11110100,  0, 0};
    vt[22] = '{22,  1, 1, 22,  9, 8'b01110000,  0, 0};
    vt[23] = '{13,  1, 0, 10, 10, 8'b11010000,  0, 0};
    vt[24] = '{40,  1, 0,  0, 12, 8'b10110100,  0, 0};
    vt[25] = '{129, 1, 0,  4,  3, 8'b11001001,  0, 0};
    vt[26] = '{3,   0, 0,  4,  3, 8'b11001001,  0, 0};
    vt[27] = '{1,   1, 0,  5,  3, 8'b11001001,  1, 0};
    vt[28] = '{270, 1, 0,  0,  0, 8'b11110110,  0, 0};
    vt[29] = '{4,   0, 1,  0,  0, 8'b11110110,  0, 0};
    vt[30] = '{1,   1, 0,  1,  0, 8'b11110000,  0, 0};

    clr  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    repeat (2) @(posedge px_clk);
    #1;
    clr = 1'b0;

    // Directed vectors from reset through mode switches, stalls and held strobes
    for (int i = 0; i < 31; i++) begin
      en   = vt[i].en;
      mode = vt[i].md;
      repeat (vt[i].n) tick();
      cmp($sformatf("vec%0d", i), got_vec(), pack(vt[i].h, vt[i].v, vt[i].fl, vt[i].x, vt[i].y));
    end

    // Asynchronous reset in the middle of a windowed frame
    en   = 1'b1;
    mode = 1'b1;
    for (int i = 0; i < 2000 && !(m_mode && m_hc == 10 && m_vc == 6); i++) tick();
    check_model("pre_reset");
    clr = 1'b1;
    #2;
    m_hc = 0; m_vc = 0; m_mode = 1'b0;
    check_model("async_reset");
    @(posedge px_clk);
    #1;
    clr = 1'b0;
    check_model("reset_hold");
    tick();
    check_model("after_reset");

    // Free-running scan; first frame must be full despite mode=1, then frame period
    since = 1;
    seen  = 1'b0;
    for (int i = 0; i < 3 * HT * VT; i++) begin
      tick();
      check_model("scanA");
      since++;
      if (frame_start) begin
        if (seen) begin
          checks++;
          if (since != HT * VT) begin
            errors++;
            $display("FAIL frame_period got %0d exp %0d", since, HT * VT);
          end
        end
        seen  = 1'b1;
        since = 0;
      end
    end

    // Random stalls and mode toggles against the reference
    for (int i = 0; i < 1600; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      tick();
      check_model("scanB");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor of the fixed 640x480 VGA sync generator; produces all raster timing for the display pipeline from the pixel clock.
- Adds registered outputs, runtime full/windowed active-area select (frame-boundary latched), a clock-enable stall, active-relative x/y coordinates, frame/line start strobes, and a configurable early-fetch window for glyph/RAM pipelines.
- Does not contain a PLL; px_clk is supplied by the parent.

Parameters:
- CW, 11, width of hc/vc/x/y.
- H_BP, 48, horizontal back porch; line starts at hc=0 in back porch.
- H_ACTIVE, 640, horizontal active pixels.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync pulse length; sync is last in line.
- V_BP, 33, vertical back porch lines.
- V_ACTIVE, 480, vertical active lines.
- V_FP, 10, vertical front porch lines.
- V_SYNC, 2, vsync pulse lines.
- HS_POL, 0, hsync asserted level.
- VS_POL, 0, vsync asserted level.
- H_WIN_OFF, 64, windowed-mode offset into horizontal active area.
- H_WIN, 512, windowed-mode active width.
- V_WIN_OFF, 112, windowed-mode offset into vertical active area.
- V_WIN, 256, windowed-mode active height.
- PREFETCH, 2, cycles by which prefetch leads the horizontal active window. Must be <= H_BP + H_WIN_OFF*mode.

Ports:
- px_clk  in  1  pixel clock.
- clr  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; 0 stalls everything.
- mode  in  1  0 = full active area, 1 = windowed; sampled at frame end.
- hc  out  CW  horizontal count, 0..H_TOTAL-1.
- vc  out  CW  vertical count, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync at HS_POL when asserted.
- vsync  out  1  vertical sync at VS_POL when asserted.
- hblank  out  1  outside selected horizontal window.
- vblank  out  1  outside selected vertical window.
- active  out  1  ~hblank & ~vblank.
- x  out  CW  hc-HS when active, else 0.
- y  out  CW  vc-VS when ~vblank, else 0.
- line_start  out  1  high while hc==0.
- frame_start  out  1  high while hc==0 && vc==0.
- prefetch  out  1  early horizontal active window.

Behaviour:
- Derived values:
  - H_TOTAL = H_BP + H_ACTIVE + H_FP + H_SYNC = 800.
  - V_TOTAL = 525.
- Selected window:
  - mode_q=0: HS = H_BP, HE = H_BP + H_ACTIVE, VS = V_BP, VE = V_BP + V_ACTIVE.
  - mode_q=1: HS = H_BP + H_WIN_OFF, HE = HS + H_WIN, VS = V_BP + V_WIN_OFF, VE = VS + V_WIN.
- Counters (on en=1 only):
  - hc increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, vc increments and wraps V_TOTAL-1 -> 0.
  - Exactly H_TOTAL cycles per line (no extra cycle at wrap).
- Output timing:
  - All outputs are registers, decoded from the next counter values, so every flag is valid in the same cycle as the hc/vc it describes. Zero-cycle skew between hc and the flags.
  - No combinational path from inputs to outputs.
- Decode rules:
  - hsync = HS_POL when hc >= H_BP + H_ACTIVE + H_FP, else ~HS_POL.
  - vsync = VS_POL when vc >= V_BP + V_ACTIVE + V_FP, else ~VS_POL.
  - Sync positions never depend on mode.
  - hblank = (hc < HS) | (hc >= HE).
  - vblank = (vc < VS) | (vc >= VE).
  - prefetch = ~vblank & (hc >= HS-PREFETCH) & (hc < HE-PREFETCH).
- Mode:
  - mode_q loads from mode on the cycle where en=1 & hc=H_TOTAL-1 & vc=V_TOTAL-1.
  - The new geometry takes effect exactly at the next frame_start.
  - mode changes at any other time are ignored until then.
- en=0: hc, vc, mode_q and all outputs hold their values, including strobes (a held strobe stays high).
- Reset (clr=1, any time, including mid-line or mid-stall):
  - hc=0, vc=0, mode_q=0.
  - hsync=~HS_POL, vsync=~VS_POL, hblank=1, vblank=1, active=0, x=0, y=0, prefetch=0, line_start=1, frame_start=1.
  - The first frame after reset is in full mode and is flagged by frame_start.
- Arithmetic:
  - Comparisons are unsigned CW-bit.
  - Parameter sets must give H_TOTAL, V_TOTAL <= 2^CW.

Test Plan:
- Reset mid-frame at hc=350, vc=200 -> same cycle hc=0, vc=0, frame_start=1, hblank=1, vblank=1, hsync=1, vsync=1. After release, next edge gives hc=1, frame_start=0.
- Full mode, en=1 for 2 frames:
  - hc 799->0 with vc+1, and vc 524->0.
  - hsync low exactly for hc 704..799 (96 cycles/line).
  - vsync low for vc 523..524.
  - frame_start period exactly 420000 cycles.
  - active first at hc=48, vc=33 with x=0, y=0; last at hc=687, vc=512 with x=639, y=479.
- Windowed mode (mode=1 before frame end):
  - active first at hc=112, vc=145 with x=0, y=0; x=511 at hc=623; y=255 at vc=400.
  - hsync/vsync positions identical to full mode.
- Mode toggled 0->1 at vc=200 -> geometry unchanged until vc=524, hc=799 completes. Windowed from the next frame_start; toggle back mid-frame likewise deferred.
- Stall: en=0 for 10 cycles at hc=300, vc=100 -> all outputs frozen for 10 cycles. en=1 resumes at hc=301 with no lost or duplicated count; frame length grows by exactly 10.
- Prefetch, PREFETCH=2:
  - Full mode: prefetch rises at hc=46, falls at hc=686, only on vc 33..512.
  - Rebuild with HS_POL=1: hsync high for hc 704..799, else low.
